// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EX stage div_* handshake.
// Signed/unsigned quotient and remainder, one bit per cycle, with a fast path, flush and divide-by-zero flag.
//
// state | meaning
// IDLE  | waiting for div_start_i; operands latched on accept
// CALC  | one restoring step per cycle, WIDTH cycles
// SIGN  | apply result signs and register the result
// DONE  | div_done_o pulse, result valid
module div_iter #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_start_i,
    input  logic               div_signed_i,
    input  logic [WIDTH-1:0]   div_data1_i,
    input  logic [WIDTH-1:0]   div_data2_i,
    input  logic               div_flush_i,
    output logic               div_ready_o,
    output logic               div_done_o,
    output logic [2*WIDTH-1:0] div_result_o,
    output logic               div_by_zero_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] prem;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] q_fin, r_fin;

    always_comb begin
        a_neg = div_signed_i & div_data1_i[WIDTH-1];
        b_neg = div_signed_i & div_data2_i[WIDTH-1];
        a_abs = a_neg ? (~div_data1_i + 1'b1) : div_data1_i;
        b_abs = b_neg ? (~div_data2_i + 1'b1) : div_data2_i;
    end

    // The stored remainder is always below the divisor, so only the shifted
    // working value needs the extra bit; the difference fits in WIDTH bits.
    always_comb begin
        shifted = {prem, dvd_q[WIDTH-1]};
        ge      = shifted >= {1'b0, dvs};
        diff    = shifted[WIDTH-1:0] - dvs;
        q_fin   = neg_q ? (~dvd_q + 1'b1) : dvd_q;
        r_fin   = neg_r ? (~prem + 1'b1) : prem;
    end

    assign div_ready_o = (state == S_IDLE);
    assign div_done_o  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            dvd_q         <= '0;
            dvs           <= '0;
            prem          <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div_result_o  <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_start_i && !div_flush_i) begin
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dvd_q <= a_abs;
                        dvs   <= b_abs;
                        prem  <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        if (div_data2_i == '0) begin
                            state         <= S_DONE;
                            div_result_o  <= {div_data1_i, {WIDTH{1'b1}}};
                            div_by_zero_o <= 1'b1;
                        end else if (EARLY_OUT && (a_abs < b_abs)) begin
                            state         <= S_DONE;
                            div_result_o  <= {div_data1_i, {WIDTH{1'b0}}};
                            div_by_zero_o <= 1'b0;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (div_flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        prem  <= ge ? diff : shifted[WIDTH-1:0];
                        dvd_q <= {dvd_q[WIDTH-2:0], ge};
                        if (cnt == '0) begin
                            state <= S_SIGN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_SIGN: begin
                    if (div_flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        div_result_o  <= {r_fin, q_fin};
                        div_by_zero_o <= 1'b0;
                        state         <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
